// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32 base opcodes, immediate formats and
// helpers that classify which source registers a given opcode reads.
package decode_pkg;

   localparam int DEFAULT_XLEN = 32;

   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM = 7'b0010011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      FMT_NONE,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J
   } imm_fmt_e;

   function automatic imm_fmt_e fmt_of(input logic [6:0] opcode);
      case (opcode)
         LOAD, JALR, OP_IMM: return FMT_I;
         STORE:              return FMT_S;
         BRANCH:             return FMT_B;
         LUI, AUIPC:         return FMT_U;
         JAL:                return FMT_J;
         default:            return FMT_NONE;
      endcase
   endfunction

   // Only registers the format really reads may create a load-use hazard.
   function automatic logic reads_rs1(input logic [6:0] opcode);
      case (opcode)
         LOAD, STORE, BRANCH, JALR, OP, OP_IMM: return 1'b1;
         default:                               return 1'b0;
      endcase
   endfunction

   function automatic logic reads_rs2(input logic [6:0] opcode);
      case (opcode)
         STORE, BRANCH, OP: return 1'b1;
         default:           return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: assembles the I/S/B/U/J immediate from the upper
// instruction bits and sign-extends it to the datapath width.
module imm_gen
   import decode_pkg::*;
#(
   parameter int XLEN = DEFAULT_XLEN
) (
   input  logic [31:7]     i_ir,
   input  imm_fmt_e        i_fmt,
   output logic [XLEN-1:0] o_imm
);

   logic [31:0] w_imm32;

   always_comb begin
      w_imm32 = '0;
      case (i_fmt)
         FMT_I:   w_imm32 = {{20{i_ir[31]}}, i_ir[31:20]};
         FMT_S:   w_imm32 = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
         FMT_B:   w_imm32 = {{19{i_ir[31]}}, i_ir[31], i_ir[7], i_ir[30:25],
                             i_ir[11:8], 1'b0};
         FMT_U:   w_imm32 = {i_ir[31:12], 12'b0};
         FMT_J:   w_imm32 = {{11{i_ir[31]}}, i_ir[31], i_ir[19:12], i_ir[20],
                             i_ir[30:21], 1'b0};
         default: w_imm32 = '0;
      endcase
   end

   assign o_imm = XLEN'(signed'(w_imm32));

endmodule

// File: rtl/decode_stage_haz.sv
// Decode stage: register file with WB bypass, immediate decode, load-use
// hazard detection and the ID/EX pipeline register with flush and backpressure.
module decode_stage_haz
   import decode_pkg::*;
#(
   parameter int XLEN      = DEFAULT_XLEN,
   parameter int NREGS     = 32,
   parameter bit BYPASS_EN = 1'b1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     if_valid_i,
   output logic                     if_ready_o,
   input  logic [31:0]              ir_i,
   input  logic [XLEN-1:0]          pc_i,
   input  logic [XLEN-1:0]          npc4_i,
   input  logic                     ex_ready_i,
   input  logic                     flush_i,
   input  logic                     wb_we_i,
   input  logic [$clog2(NREGS)-1:0] wb_addr_i,
   input  logic [XLEN-1:0]          wb_data_i,
   output logic                     ex_valid_o,
   output logic [XLEN-1:0]          rs1_val_o,
   output logic [XLEN-1:0]          rs2_val_o,
   output logic [XLEN-1:0]          imm_o,
   output logic [XLEN-1:0]          pc_o,
   output logic [XLEN-1:0]          npc4_o,
   output logic [4:0]               rd_o,
   output logic [4:0]               rs1_o,
   output logic [4:0]               rs2_o,
   output logic [6:0]               opcode_o,
   output logic                     stall_o
);

   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0] r_rf [NREGS];

   logic            r_ex_valid;
   logic [XLEN-1:0] r_rs1_val;
   logic [XLEN-1:0] r_rs2_val;
   logic [XLEN-1:0] r_imm;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_npc4;
   logic [4:0]      r_rd;
   logic [4:0]      r_rs1;
   logic [4:0]      r_rs2;
   logic [6:0]      r_opcode;

   logic [6:0]      w_opcode;
   logic [4:0]      w_rd;
   logic [4:0]      w_rs1;
   logic [4:0]      w_rs2;
   logic [AW-1:0]   w_rs1_idx;
   logic [AW-1:0]   w_rs2_idx;
   imm_fmt_e        w_fmt;
   logic [XLEN-1:0] w_imm;
   logic [XLEN-1:0] w_rs1_val;
   logic [XLEN-1:0] w_rs2_val;
   logic            w_uses_rs1;
   logic            w_uses_rs2;
   logic            w_load_use;
   logic            w_advance;
   logic            w_accept;

   assign w_opcode   = ir_i[6:0];
   assign w_rd       = ir_i[11:7];
   assign w_rs1      = ir_i[19:15];
   assign w_rs2      = ir_i[24:20];
   assign w_rs1_idx  = w_rs1[AW-1:0];
   assign w_rs2_idx  = w_rs2[AW-1:0];
   assign w_fmt      = fmt_of(w_opcode);
   assign w_uses_rs1 = reads_rs1(w_opcode);
   assign w_uses_rs2 = reads_rs2(w_opcode);

   imm_gen #(
      .XLEN (XLEN)
   ) u_imm_gen (
      .i_ir  (ir_i[31:7]),
      .i_fmt (w_fmt),
      .o_imm (w_imm)
   );

   // Entry 0 is never written, so it reads as zero without a special case.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) begin
            r_rf[i] <= '0;
         end
      end else if (wb_we_i && (wb_addr_i != '0)) begin
         r_rf[wb_addr_i] <= wb_data_i;
      end
   end

   always_comb begin
      w_rs1_val = r_rf[w_rs1_idx];
      w_rs2_val = r_rf[w_rs2_idx];
      if (BYPASS_EN && wb_we_i && (wb_addr_i == w_rs1_idx) && (w_rs1_idx != '0)) begin
         w_rs1_val = wb_data_i;
      end
      if (BYPASS_EN && wb_we_i && (wb_addr_i == w_rs2_idx) && (w_rs2_idx != '0)) begin
         w_rs2_val = wb_data_i;
      end
   end

   // Register addresses alias modulo NREGS, so the hazard compare does too.
   always_comb begin
      w_load_use = 1'b0;
      if (r_ex_valid && (r_opcode == LOAD) && (r_rd[AW-1:0] != '0)) begin
         w_load_use = (w_uses_rs1 && (r_rd[AW-1:0] == w_rs1_idx)) ||
                      (w_uses_rs2 && (r_rd[AW-1:0] == w_rs2_idx));
      end
   end

   assign w_advance = ex_ready_i | ~r_ex_valid;
   assign w_accept  = if_valid_i & w_advance & ~w_load_use & ~flush_i;

   // A flush drops the incoming instruction, so fetch may always move on.
   assign if_ready_o = rst & (flush_i | (w_advance & ~w_load_use));
   assign stall_o    = rst & ~flush_i & if_valid_i & w_load_use & w_advance;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ex_valid <= 1'b0;
         r_rs1_val  <= '0;
         r_rs2_val  <= '0;
         r_imm      <= '0;
         r_pc       <= '0;
         r_npc4     <= '0;
         r_rd       <= '0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_opcode   <= '0;
      end else if (flush_i) begin
         r_ex_valid <= 1'b0;
      end else if (w_advance) begin
         r_ex_valid <= w_accept;
         if (w_accept) begin
            r_rs1_val <= w_rs1_val;
            r_rs2_val <= w_rs2_val;
            r_imm     <= w_imm;
            r_pc      <= pc_i;
            r_npc4    <= npc4_i;
            r_rd      <= w_rd;
            r_rs1     <= w_rs1;
            r_rs2     <= w_rs2;
            r_opcode  <= w_opcode;
         end
      end
   end

   assign ex_valid_o = r_ex_valid;
   assign rs1_val_o  = r_rs1_val;
   assign rs2_val_o  = r_rs2_val;
   assign imm_o      = r_imm;
   assign pc_o       = r_pc;
   assign npc4_o     = r_npc4;
   assign rd_o       = r_rd;
   assign rs1_o      = r_rs1;
   assign rs2_o      = r_rs2;
   assign opcode_o   = r_opcode;

endmodule
